// File: rtl/pipe_hazard_ctrl.sv
// Hazard arbiter for PC, IF/ID, ID/EX and EX/MEM/WB: load-use stalls, jump flushes, data-bus waits.
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int BUS_TO       = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_mem_re_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        dmem_busy_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        pipe_stall_o,
  output logic        bus_timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int MAXC = (FLUSH_CYCLES > BUS_TO) ? FLUSH_CYCLES : BUS_TO;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {RUN, FLUSH, BUS_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rst_q;
  logic          mask;
  logic          load_use;

  // Outputs are forced quiet in the reset cycle and the one following it.
  assign mask     = rst | rst_q;
  assign load_use = ex_mem_re_i && (ex_rd_addr_i != 5'd0) &&
                    ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      rst_q <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rst_q <= 1'b0;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    jump_en_o     = 1'b0;
    jump_addr_o   = '0;
    pc_hold_o     = 1'b0;
    if_id_hold_o  = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    pipe_stall_o  = 1'b0;
    bus_timeout_o = 1'b0;
    if (mask) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RUN: begin
          if (dmem_busy_i) begin
            pc_hold_o    = 1'b1;
            if_id_hold_o = 1'b1;
            pipe_stall_o = 1'b1;
            cnt_nxt      = '0;
            state_nxt    = BUS_WAIT;
          end else if (jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              cnt_nxt   = CW'(FLUSH_CYCLES - 1);
            end
          end else if (load_use) begin
            pc_hold_o     = 1'b1;
            if_id_hold_o  = 1'b1;
            id_ex_flush_o = 1'b1;
          end
        end
        FLUSH: begin
          // A bus stall preempts the remaining bubbles; the drop is intentional.
          if (dmem_busy_i) begin
            pc_hold_o    = 1'b1;
            if_id_hold_o = 1'b1;
            pipe_stall_o = 1'b1;
            cnt_nxt      = '0;
            state_nxt    = BUS_WAIT;
          end else begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            cnt_nxt       = cnt - CW'(1);
            if (cnt <= CW'(1)) begin
              cnt_nxt   = '0;
              state_nxt = RUN;
            end
          end
        end
        BUS_WAIT: begin
          if (!dmem_busy_i) begin
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else if (cnt == CW'(BUS_TO - 1)) begin
            bus_timeout_o = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            cnt_nxt       = '0;
            state_nxt     = RUN;
          end else begin
            pc_hold_o    = 1'b1;
            if_id_hold_o = 1'b1;
            pipe_stall_o = 1'b1;
            cnt_nxt      = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_hold_o && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if ((jump_en_o || bus_timeout_o) && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule
